perf_counter_bank: RTL

Parametrised, memory-mapped bank of event counters for the pipelined LC-3b core. It replaces the fixed set of nine 16-bit hit/miss/branch/stall counters and their separate reset wires. The bank adds:
- a configurable channel count and counter width;
- per-channel cycle or run-length counting;
- a global enable;
- a saturate/wrap mode;
- software clear through stores.

It sits beside the MEM stage and overlays its read data onto the data path whenever a load hits the counter window.

---
 rtl/perf_counter_bank_pkg.sv | 25 ++
 rtl/perf_channel.sv | 63 ++++++
 rtl/perf_counter_bank.sv | 82 ++++++++
 3 files changed

// File: rtl/perf_counter_bank_pkg.sv
// Shared types and constants for the performance counter bank.
package perf_counter_bank_pkg;

    // Default byte address of counter channel 0.
    localparam logic [15:0] PERF_BASE_ADDR = 16'hFFC0;

    // Run trackers are wide enough for thresholds up to 15.
    localparam int PERF_RUN_W = 4;

    // CTRL register layout: bit0 EN, bit1 SAT.
    typedef struct packed {
        logic sat;
        logic en;
    } perf_ctrl_t;

    // Per-channel counting mode.
    typedef enum logic {
        PERF_RUN   = 1'b0,
        PERF_CYCLE = 1'b1
    } perf_mode_t;

    // Counting enabled, wrap arithmetic.
    localparam perf_ctrl_t PERF_CTRL_RESET = '{sat: 1'b0, en: 1'b1};

endpackage

// File: rtl/perf_channel.sv
// One counter channel: counter, run tracker, saturate/wrap increment
// and the store-load port.
module perf_channel
    import perf_counter_bank_pkg::*;
#(
    parameter int         CNT_WIDTH  = 16,
    parameter int         RUN_THRESH = 2,
    parameter perf_mode_t MODE       = PERF_CYCLE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 sat,
    input  logic                 ev,
    input  logic                 wr,
    input  logic [CNT_WIDTH-1:0] wdata,
    output logic [CNT_WIDTH-1:0] count
);

    localparam logic [PERF_RUN_W-1:0] THRESH = PERF_RUN_W'(RUN_THRESH);

    logic [PERF_RUN_W-1:0] run;
    logic [PERF_RUN_W-1:0] run_next;
    logic                  bump;
    logic [CNT_WIDTH-1:0]  count_next;

    // All-ones either holds (saturating) or rolls over to zero.
    function automatic logic [CNT_WIDTH-1:0] incr(input logic [CNT_WIDTH-1:0] c,
                                                   input logic s);
        if (&c) begin
            return s ? c : '0;
        end
        return c + CNT_WIDTH'(1);
    endfunction

    // Decide whether this cycle bumps the counter and advance the run tracker.
    always_comb begin
        run_next = '0;
        bump     = 1'b0;
        if (MODE == PERF_CYCLE) begin
            bump = en & ev;
        end else if (en && ev) begin
            run_next = (run == THRESH) ? THRESH : run + PERF_RUN_W'(1);
            bump     = (run == THRESH - PERF_RUN_W'(1));
        end
        count_next = bump ? incr(count, sat) : count;
    end

    // Reset beats a store, and a store beats a simultaneous event.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            run   <= '0;
        end else if (wr) begin
            count <= wdata;
            run   <= '0;
        end else begin
            count <= count_next;
            run   <= run_next;
        end
    end

endmodule

// File: rtl/perf_counter_bank.sv
// Memory-mapped event counter bank beside the MEM stage: address decode,
// CTRL register and the load-data overlay.
module perf_counter_bank
    import perf_counter_bank_pkg::*;
#(
    parameter int          NUM_CH     = 9,
    parameter int          CNT_WIDTH  = 16,
    parameter logic [15:0] BASE_ADDR  = PERF_BASE_ADDR,
    parameter int          RUN_THRESH = 2,
    parameter logic [NUM_CH-1:0] CH_MODE = '1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] events,
    input  logic              mmio_read,
    input  logic              mmio_write,
    input  logic [15:0]       mmio_addr,
    input  logic [15:0]       mmio_wdata,
    input  logic [15:0]       mem_rdata_in,
    output logic [15:0]       mem_rdata_out,
    output logic              mmio_hit
);

    logic [15:0]          off;
    logic [14:0]          idx;
    logic                 ch_hit;
    logic                 ctrl_hit;
    perf_ctrl_t           ctrl;
    logic [CNT_WIDTH-1:0] count [NUM_CH];
    logic [15:0]          sel;
    logic                 unused_bits;

    // Word index relative to the window base; byte bit 0 is ignored.
    assign off      = mmio_addr - BASE_ADDR;
    assign idx      = off[15:1];
    assign ch_hit   = (idx < 15'(NUM_CH));
    assign ctrl_hit = (idx == 15'(NUM_CH));
    assign mmio_hit = ch_hit | ctrl_hit;

    assign unused_bits = ^{off[0], mmio_wdata};

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        perf_channel #(
            .CNT_WIDTH (CNT_WIDTH),
            .RUN_THRESH(RUN_THRESH),
            .MODE      (CH_MODE[i] ? PERF_CYCLE : PERF_RUN)
        ) u_ch (
            .clk  (clk),
            .reset(reset),
            .en   (ctrl.en),
            .sat  (ctrl.sat),
            .ev   (events[i]),
            .wr   (mmio_write && ch_hit && (idx == 15'(i))),
            .wdata(mmio_wdata[CNT_WIDTH-1:0]),
            .count(count[i])
        );
    end

    // CTRL register; an EN change only affects events from the next cycle on.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl <= PERF_CTRL_RESET;
        end else if (mmio_write && ctrl_hit) begin
            ctrl <= perf_ctrl_t'(mmio_wdata[1:0]);
        end
    end

    // Select the addressed register, zero-extended to the data-path width.
    always_comb begin
        sel = '0;
        if (ctrl_hit) begin
            sel = {14'b0, ctrl};
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (idx == 15'(i)) begin
                sel = 16'(count[i]);
            end
        end
        mem_rdata_out = (mmio_read && mmio_hit) ? sel : mem_rdata_in;
    end

endmodule
